// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the 3x3 convolution window generator: pixel width
// default, window geometry, slot indexing and FSM state encodings. These are
// the same values the conv-core side blocks expect.
package conv_window_gen_pkg;

    // Default pixel width; a window word is WIN_N pixels wide.
    localparam int DEF_DATA_W = 10;

    // Window geometry: 3 rows x 3 columns, row-major slots.
    localparam int WIN_DIM = 3;
    localparam int WIN_N   = WIN_DIM * WIN_DIM;

    // FSM state encodings (kept as plain constants for legacy consumers).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Slot index of window row r, column c (row 0 = oldest row, col 0 = leftmost).
    function automatic int slot_idx(input int r, input int c);
        return (WIN_DIM * r) + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage. The read port is combinational so the
// value stored at the current column is available in the same cycle that a
// new pixel overwrites it (read-before-write). Contents are not reset.
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Old contents of the addressed column, seen before this cycle's write.
    assign o_rdata = r_mem[i_addr];

    // Store the incoming pixel at the current column when the row advances.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Producer side of the 3x3 convolution datapath. Takes a raster-order pixel
// stream, keeps the two previous rows in line buffers and emits every fully
// populated 3x3 window (no padding) as one packed word, slot k = 3*r + c at
// [k*DATA_W +: DATA_W], slot 0 = top-left, slot 8 = newest pixel.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIN_N*DATA_W-1:0] o_window,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WIN_W = WIN_N * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_WIN0  = COL_W'(WIN_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_WIN0  = ROW_W'(WIN_DIM - 1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    // Control state
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_busy;
    logic              r_done;

    // Output register
    logic              r_valid;
    logic [WIN_W-1:0]  r_window;

    // Window columns. The leftmost column of the 3x3 array is only ever
    // shifted out, so just the two most recent columns are stored; the third
    // (newest) column comes straight from the line buffers and i_data.
    logic [DATA_W-1:0] r_sr_c0 [0:WIN_DIM-1];
    logic [DATA_W-1:0] r_sr_c1 [0:WIN_DIM-1];
    logic [DATA_W-1:0] w_newcol [0:WIN_DIM-1];

    // Datapath / handshake wires
    logic [DATA_W-1:0] w_lb0_q;
    logic [DATA_W-1:0] w_lb1_q;
    logic [WIN_W-1:0]  w_window;
    logic              w_run;
    logic              w_ready;
    logic              w_accept;
    logic              w_take;
    logic              w_last_px;
    logic              w_emit;

    // Row memories: lb0 holds the previous row, lb1 the row before that.
    conv_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .i_clk   (i_clk),
        .i_en    (w_accept),
        .i_addr  (r_col),
        .i_wdata (i_data),
        .o_rdata (w_lb0_q)
    );

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .i_clk   (i_clk),
        .i_en    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_q),
        .o_rdata (w_lb1_q)
    );

    // Handshake: a single output register, so a pixel may enter only when
    // that register is empty or being drained this cycle.
    assign w_run     = (r_state == ST_RUN);
    assign w_ready   = w_run & (~r_valid | i_ready);
    assign w_accept  = i_valid & w_ready;
    assign w_take    = r_valid & i_ready;
    assign w_last_px = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_emit    = w_accept && (r_row >= ROW_WIN0) && (r_col >= COL_WIN0);

    // Newest column, oldest row on top.
    assign w_newcol[0] = w_lb1_q;
    assign w_newcol[1] = w_lb0_q;
    assign w_newcol[2] = i_data;

    // Assemble the window that results from shifting in the current pixel.
    always_comb begin
        w_window = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            w_window[slot_idx(r, 0)*DATA_W +: DATA_W] = r_sr_c0[r];
            w_window[slot_idx(r, 1)*DATA_W +: DATA_W] = r_sr_c1[r];
            w_window[slot_idx(r, 2)*DATA_W +: DATA_W] = w_newcol[r];
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last_px) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The last pixel always produces a window, so the output
                // register is full here until that window is taken.
                if (w_take) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy flag and end-of-frame pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (r_state == ST_FLUSH) && w_take;
        end
    end

    // Raster position of the next pixel; frozen on idle beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_ONE;
                end
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end
    end

    // Shift the window one column left on every accepted pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                r_sr_c0[r] <= '0;
                r_sr_c1[r] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                r_sr_c0[r] <= r_sr_c1[r];
                r_sr_c1[r] <= w_newcol[r];
            end
        end
    end

    // Output register: load a new window, or clear valid once it is taken.
    // A simultaneous take and emit keeps valid high with the new window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_window <= '0;
        end else if (w_emit) begin
            r_valid  <= 1'b1;
            r_window <= w_window;
        end else if (w_take) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_ready  = w_ready;
    assign o_valid  = r_valid;
    assign o_window = r_window;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
